// File: rtl/calc_pkg.sv
// Shared types and constants for the ALU result path: FSM encodings and
// BCD digit geometry used by the binary-to-BCD converter.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned      BCD_W       = 4;
    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [BCD_W-1:0] ADD3_VALUE  = 4'd3;

endpackage

// File: rtl/bcd_add3_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// before the shift so that it carries correctly into the next digit.
module bcd_add3_adj
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= ADD3_THRESH) begin
            dout = din + ADD3_VALUE;
        end
    end

endmodule

// File: rtl/alu_result_bcd_conv.sv
// Sign-magnitude ALU result to packed BCD, one double-dabble step per clock,
// with leading-zero blanking flags for the 7-segment driver.
module alu_result_bcd_conv
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          magnitude,
    input  logic                      sign_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      sign_out,
    output logic [DIGITS-1:0]         lz_blank
);

    localparam int unsigned BCD_BITS = BCD_W * DIGITS;
    localparam int unsigned SR_W     = BCD_BITS + WIDTH;
    localparam int unsigned CNT_W    = $clog2(WIDTH + 1);

    if (longint'(10) ** DIGITS <= (longint'(1) << WIDTH) - 1) begin : g_param_check
        $error("alu_result_bcd_conv: DIGITS too small to hold 2**WIDTH-1");
    end

    state_t                state_q, state_d;
    logic [SR_W-1:0]       shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sign_lat_q, sign_lat_d;
    logic [BCD_BITS-1:0]   bcd_q, bcd_d;
    logic                  sign_out_q, sign_out_d;
    logic [DIGITS-1:0]     lz_q, lz_d;

    logic [BCD_BITS-1:0]   bcd_adj;
    logic [SR_W-1:0]       sr_adj;
    logic [SR_W-1:0]       sr_shift;
    logic [BCD_BITS-1:0]   final_bcd;
    logic [DIGITS-1:0]     lz_next;
    logic                  above_zero;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3_adj u_adj (
            .din  (shreg_q[WIDTH + g*BCD_W +: BCD_W]),
            .dout (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        bcd       = bcd_q;
        sign_out  = sign_out_q;
        lz_blank  = lz_q;
    end

    // The result captured on the last step is the post-shift value, so the
    // adjust-then-shift step is computed once and reused for both.
    always_comb begin
        sr_adj    = {bcd_adj, shreg_q[WIDTH-1:0]};
        sr_shift  = sr_adj << 1;
        final_bcd = sr_shift[SR_W-1 -: BCD_BITS];
    end

    always_comb begin
        above_zero = 1'b1;
        lz_next    = '0;
        for (int unsigned k = 0; k < DIGITS - 1; k++) begin
            above_zero = above_zero &
                         (final_bcd[(DIGITS-1-k)*BCD_W +: BCD_W] == '0);
            lz_next[DIGITS-1-k] = above_zero;
        end
    end

    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        sign_lat_d = sign_lat_q;
        bcd_d      = bcd_q;
        sign_out_d = sign_out_q;
        lz_d       = lz_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d    = SR_W'(magnitude);
                    sign_lat_d = sign_in & (magnitude != '0);
                    cnt_d      = CNT_W'(WIDTH);
                end
            end
            ST_SHIFT: begin
                shreg_d = sr_shift;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d      = final_bcd;
                    sign_out_d = sign_lat_q;
                    lz_d       = lz_next;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q    <= '0;
            cnt_q      <= '0;
            sign_lat_q <= 1'b0;
            bcd_q      <= '0;
            sign_out_q <= 1'b0;
            lz_q       <= '0;
        end else begin
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            sign_lat_q <= sign_lat_d;
            bcd_q      <= bcd_d;
            sign_out_q <= sign_out_d;
            lz_q       <= lz_d;
        end
    end

endmodule

// File: tb/tb_alu_result_bcd_conv.sv
// Scoreboard bench for alu_result_bcd_conv: directed vectors push expected
// results; a negedge monitor pops and compares on each output handshake.
module tb_alu_result_bcd_conv;

    localparam int WIDTH  = 9;
    localparam int DIGITS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  magnitude;
    logic        sign_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;
    logic        sign_out;
    logic [2:0]  lz_blank;

    typedef struct packed {
        logic [11:0] bcd;
        logic        sign;
        logic [2:0]  lz;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    alu_result_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .magnitude (magnitude),
        .sign_in   (sign_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .sign_out  (sign_out),
        .lz_blank  (lz_blank)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: actual bcd=0x%0h required no output", bcd);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_bcd", 32'(bcd), 32'(mon_e.bcd));
                chk("sb_sign", 32'(sign_out), 32'(mon_e.sign));
                chk("sb_lz", 32'(lz_blank), 32'(mon_e.lz));
            end
        end
    end

    // Drives one input and returns the cycle index of the capture edge, 1ns past it.
    task automatic issue(input logic [8:0] m, input logic s, output int cap);
        int n;
        n = 0;
        magnitude = m;
        sign_in   = s;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        cap = cyc;
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 60);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_return", 32'(in_ready), 32'd1);
    endtask

    task automatic run(input logic [8:0] m, input logic s,
                       input logic [11:0] b, input logic [2:0] lz, input logic so);
        exp_t x;
        int   c;
        int   n;
        x = '{bcd: b, sign: so, lz: lz};
        sb.push_back(x);
        issue(m, s, c);
        in_valid = 1'b0;
        wait_valid(n);
        chk("latency", 32'(n), 32'(WIDTH));
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t x;
        int   c, c1, c2, c3, n;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        magnitude = '0;
        sign_in   = 1'b0;

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_sign", 32'(sign_out), 32'd0);
        chk("rst_lz", 32'(lz_blank), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Zero magnitude: negative sign suppressed, upper digits blanked
        run(9'd0, 1'b1, 12'h000, 3'b110, 1'b0);
        run(9'd511, 1'b0, 12'h511, 3'b000, 1'b0);
        run(9'd255, 1'b1, 12'h255, 3'b000, 1'b1);
        run(9'd7, 1'b0, 12'h007, 3'b110, 1'b0);
        run(9'd40, 1'b0, 12'h040, 3'b100, 1'b0);

        // Back-pressure: result held, new input ignored
        out_ready = 1'b0;
        x = '{bcd: 12'h123, sign: 1'b1, lz: 3'b000};
        sb.push_back(x);
        issue(9'd123, 1'b1, c);
        in_valid = 1'b0;
        wait_valid(n);
        chk("hold_latency", 32'(n), 32'(WIDTH));
        magnitude = 9'd5;
        sign_in   = 1'b0;
        in_valid  = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_bcd", 32'(bcd), 32'h123);
            chk("hold_sign", 32'(sign_out), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        run(9'd5, 1'b0, 12'h005, 3'b110, 1'b0);

        // Asynchronous reset mid-conversion discards the result
        issue(9'd200, 1'b0, c);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_bcd", 32'(bcd), 32'd0);
        chk("async_rst_sign", 32'(sign_out), 32'd0);
        chk("async_rst_lz", 32'(lz_blank), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run(9'd100, 1'b0, 12'h100, 3'b000, 1'b0);

        // Back-to-back with in_valid held high
        x = '{bcd: 12'h001, sign: 1'b0, lz: 3'b110};
        sb.push_back(x);
        x = '{bcd: 12'h002, sign: 1'b0, lz: 3'b110};
        sb.push_back(x);
        x = '{bcd: 12'h003, sign: 1'b0, lz: 3'b110};
        sb.push_back(x);
        issue(9'd1, 1'b0, c1);
        issue(9'd2, 1'b0, c2);
        issue(9'd3, 1'b0, c3);
        in_valid = 1'b0;
        chk("b2b_gap1", 32'(c2 - c1), 32'(WIDTH + 2));
        chk("b2b_gap2", 32'(c3 - c2), 32'(WIDTH + 2));
        wait_valid(n);
        chk("b2b_latency", 32'(n), 32'(WIDTH));
        wait_idle();

        repeat (5) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
